// File: rtl/rng_seq_pkg.sv
// rng_seq_pkg: shared states, status codes and default widths for the RNG FIFO sequencer
package rng_seq_pkg;
  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} seq_state_t;
  typedef enum logic [1:0] {ST_OK = 2'd0, ST_FULL = 2'd1, ST_ABORT = 2'd2} seq_status_t;
  localparam int DATA_WIDTH_DEF  = 4;
  localparam int CNT_WIDTH_DEF   = 5;
  localparam int TIMER_WIDTH_DEF = 26;
endpackage

// File: rtl/interval_timer.sv
// interval_timer: loadable down-counter that stops at zero and flags it
module interval_timer #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);
  logic [WIDTH-1:0] count;
  // load wins over counting; counting never goes below zero
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else count <= load ? load_value : (en && count != '0) ? count - WIDTH'(1) : count;
  assign zero = count == '0;
endmodule

// File: rtl/rng_fifo_sequencer.sv
// rng_fifo_sequencer: fills the FIFO from the LFSR on request and drains it at a paced interval
module rng_fifo_sequencer
  import rng_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int TIMER_WIDTH = TIMER_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   fill_req,
  input  logic                   drain_req,
  input  logic                   abort,
  input  logic [CNT_WIDTH-1:0]   fill_len,
  input  logic [TIMER_WIDTH-1:0] drain_interval,
  input  logic [DATA_WIDTH-1:0]  lfsr_data,
  input  logic                   lfsr_valid,
  output logic                   lfsr_enable,
  input  logic                   fifo_full,
  input  logic                   fifo_empty,
  output logic                   fifo_push,
  output logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_pop,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             status
);
  seq_state_t           state;
  seq_status_t          stat;
  logic [CNT_WIDTH-1:0]   remaining;
  logic [TIMER_WIDTH-1:0] interval;
  logic timer_zero, push, pop, fill_end, drain_end, full_hit;
  assign full_hit  = fifo_full && remaining != '0;
  assign push      = state == FILL && !abort && lfsr_valid && !full_hit && remaining != '0;
  assign pop       = state == DRAIN && !abort && timer_zero && !fifo_empty;
  assign fill_end  = abort || full_hit || remaining == '0 || (push && remaining == CNT_WIDTH'(1));
  assign drain_end = abort || (timer_zero && fifo_empty);
  assign fifo_push   = push;
  assign lfsr_enable = push;
  assign fifo_pop    = pop;
  assign fifo_data   = lfsr_data;
  assign status      = stat;
  interval_timer #(.WIDTH(TIMER_WIDTH)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       ((state == IDLE && !fill_req && drain_req) || pop),
    .en         (state == DRAIN && !abort),
    .load_value (state == IDLE ? drain_interval : interval),
    .zero       (timer_zero)
  );
  // sequencing FSM with registered busy/done/status
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      stat      <= ST_OK;
      remaining <= '0;
      interval  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (fill_req) begin
            remaining <= fill_len;
            state     <= fill_len == '0 ? DONE : FILL;
            busy      <= fill_len != '0;
            done      <= fill_len == '0;
            if (fill_len == '0) stat <= ST_OK;
          end else if (drain_req) begin
            interval <= drain_interval;
            state    <= DRAIN;
            busy     <= 1'b1;
          end
        FILL: begin
          if (push) remaining <= remaining - CNT_WIDTH'(1);
          if (fill_end) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            stat  <= abort ? ST_ABORT : full_hit ? ST_FULL : ST_OK;
          end
        end
        DRAIN:
          if (drain_end) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            stat  <= abort ? ST_ABORT : ST_OK;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/rng_fifo_sequencer.md
Name: rng_fifo_sequencer

Overview:
- Sequences the LFSR → FIFO datapath on the 50 MHz fabric clock.
- On a fill request, pushes a programmed number of LFSR words into the FIFO, advancing the LFSR once per pushed word.
- On a drain request, pops the FIFO at a programmable interval until the FIFO is empty, so the LED display steps through the stored words.
- Replaces direct button-pulse wiring; the button edge pulses become fill_req and drain_req.

Parameters:
- DATA_WIDTH, 4: LFSR output / FIFO word width.
- CNT_WIDTH, 5: width of fill_len and of the remaining-word counter; must cover FIFO depth 16.
- TIMER_WIDTH, 26: width of drain_interval and of the drain timer.

Ports:
- clk  in  1  fabric clock (clk_out1 domain).
- reset_n  in  1  asynchronous, active-low reset.
- fill_req  in  1  single-cycle request to start a fill.
- drain_req  in  1  single-cycle request to start a drain.
- abort  in  1  level; terminates any operation.
- fill_len  in  CNT_WIDTH  number of words to push; sampled on fill_req acceptance.
- drain_interval  in  TIMER_WIDTH  cycles between pops; sampled on drain_req acceptance.
- lfsr_data  in  DATA_WIDTH  current LFSR output.
- lfsr_valid  in  1  LFSR output valid.
- lfsr_enable  out  1  advance LFSR one step.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- fifo_push  out  1  FIFO push strobe.
- fifo_data  out  DATA_WIDTH  FIFO write data; equals lfsr_data at all times.
- fifo_pop  out  1  FIFO pop strobe.
- busy  out  1  high in FILL or DRAIN.
- done  out  1  one-cycle completion pulse.
- status  out  2  result of the last operation: OK=0, FULL=1, ABORT=2; held until the next operation completes.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low. In reset: state=IDLE, remaining=0, timer=0, status=OK, done=0, busy=0. fifo_push, fifo_pop and lfsr_enable are 0 in reset and whenever abort=1.
- States: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - fill_req=1 → FILL next cycle; remaining←fill_len.
  - Otherwise drain_req=1 → DRAIN next cycle; timer←drain_interval.
  - fill_req has priority if both requests arrive together.
  - fill_len=0 → DONE directly, with status OK.
- FILL:
  - push_ok = lfsr_valid & ~fifo_full & (remaining≠0).
  - fifo_push = lfsr_enable = push_ok. This is combinational (Mealy), the same cycle; first push can occur 1 cycle after fill_req.
  - remaining decrements on each push.
  - After the push that makes remaining=0 → DONE, status OK.
  - fifo_full=1 while remaining≠0 → DONE with status FULL and no push in that cycle. The words already pushed remain in the FIFO.
  - lfsr_valid=0 → stall: no push, no transition.
- DRAIN:
  - timer≠0: timer decrements each cycle.
  - timer=0 and ~fifo_empty: fifo_pop=1 for that cycle; timer←drain_interval.
  - timer=0 and fifo_empty: → DONE, status OK.
  - drain_interval=0: pop every cycle while non-empty. The FIFO flag updates one cycle after the pop, so a 1-entry FIFO yields exactly one pop.
- DONE: done=1 for exactly this cycle, then → IDLE.
- Requests in FILL, DRAIN or DONE are ignored, not queued.
- abort (any non-IDLE state): → DONE next cycle, status ABORT. No push or pop in the abort cycle. abort in IDLE: no effect.
- busy is registered from the state: 1 in FILL and DRAIN, 0 in IDLE and DONE.
- Widths: counters are unsigned and never wrap below 0. Decrement only when the value is ≠0.

Decomposition:
- Package rng_seq_pkg: state enum seq_state_t {IDLE, FILL, DRAIN, DONE}; status enum seq_status_t {ST_OK, ST_FULL, ST_ABORT}; default width constants.
- One sub-module, interval_timer: loadable down-counter with load, load_value, zero outputs. It is instantiated for the drain timer.

Test Plan:
- Fill with FIFO empty, lfsr_valid=1: fill_req, fill_len=5 → 5 consecutive pushes on cycles 1–5; lfsr_enable coincident with each push; done on cycle 6; status OK; FIFO holds the 5 LFSR words in order.
- Fill overrun: fill_len=20, FIFO depth 16 → exactly 16 pushes, then done with status FULL; no push while fifo_full=1.
- Drain paced: FIFO holds 3 words, drain_interval=4 → pops at cycles 5, 10, 15; done after the empty timeout; popped data matches the fill order.
- drain_interval=0 with 2 entries → 2 pops on consecutive cycles, then done with status OK.
- Abort mid-fill after 2 pushes → no further push; done next cycle with status ABORT; busy=0 after.
- fill_req and drain_req in the same cycle → FILL taken. drain_req during FILL → ignored. Reset asserted mid-drain → all outputs 0 and state IDLE immediately (asynchronous).
